// File: rtl/muldiv_unit.sv
// RV M-extension execute unit: fixed-latency multiplier beside an
// iterative restoring divider, one operation in flight.
module muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2,
    parameter int DIV_RADIX  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enabled,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            ready,
    output logic            completed,
    output logic [XLEN-1:0] result
);

    localparam int DIV_ITERS = XLEN / DIV_RADIX;
    localparam int CNT_MAX   = (DIV_ITERS > MUL_STAGES) ? DIV_ITERS - 1
                                                        : MUL_STAGES - 1;
    localparam int CNT_W     = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_STAGES - 1);
    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_ITERS - 1);

    if (MUL_STAGES < 1) begin : g_bad_mul_stages
        $error("muldiv_unit: MUL_STAGES must be >= 1");
    end

    if (!(DIV_RADIX == 1 || DIV_RADIX == 2 || DIV_RADIX == 4) ||
        (XLEN % DIV_RADIX) != 0) begin : g_bad_div_radix
        $error("muldiv_unit: DIV_RADIX must be 1, 2 or 4 and divide XLEN");
    end

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("muldiv_unit: XLEN must be 32 or 64");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV_CALC,
        S_DIV_FIX
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_op;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [XLEN-1:0]   r_dvs;
    logic [XLEN-1:0]   r_quo;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_result;
    logic              r_completed;

    assign completed = r_completed;
    assign result    = r_result;

    // ---------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ready       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (enabled) begin
                    w_state_nxt = op[2] ? S_DIV_CALC : S_MUL;
                end
            end
            S_MUL: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DIV_CALC: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_DIV_FIX;
                end
            end
            S_DIV_FIX: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Operand magnitudes captured at accept (signed DIV/REM only)
    // ---------------------------------------------------------------
    logic            w_in_sgn;
    logic [XLEN-1:0] w_abs1;
    logic [XLEN-1:0] w_abs2;

    assign w_in_sgn = ~op[0];
    assign w_abs1   = (w_in_sgn & rs1[XLEN-1]) ? -rs1 : rs1;
    assign w_abs2   = (w_in_sgn & rs2[XLEN-1]) ? -rs2 : rs2;

    // ---------------------------------------------------------------
    // Multiplier: operands extended per signedness, low 2*XLEN kept
    // ---------------------------------------------------------------
    logic              w_a_sgn;
    logic              w_b_sgn;
    logic [2*XLEN-1:0] w_ma;
    logic [2*XLEN-1:0] w_mb;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_mul_res;

    assign w_a_sgn   = (r_op != 2'b11);
    assign w_b_sgn   = ~r_op[1];
    assign w_ma      = {{XLEN{w_a_sgn & r_a[XLEN-1]}}, r_a};
    assign w_mb      = {{XLEN{w_b_sgn & r_b[XLEN-1]}}, r_b};
    assign w_prod    = w_ma * w_mb;
    assign w_mul_res = (r_op == 2'b00) ? w_prod[XLEN-1:0]
                                       : w_prod[2*XLEN-1:XLEN];

    // ---------------------------------------------------------------
    // Restoring divide: DIV_RADIX quotient bits per cycle
    // ---------------------------------------------------------------
    logic [XLEN:0]   w_trial;
    logic            w_ge;
    logic [XLEN-1:0] w_sub;
    logic [XLEN-1:0] w_quo_n;
    logic [XLEN-1:0] w_rem_n;

    always_comb begin
        w_trial = '0;
        w_ge    = 1'b0;
        w_sub   = '0;
        w_quo_n = r_quo;
        w_rem_n = r_rem;
        for (int i = 0; i < DIV_RADIX; i++) begin
            w_trial = {w_rem_n, w_quo_n[XLEN-1]};
            // A set top bit means the trial already exceeds any divisor.
            w_ge    = w_trial[XLEN] | (w_trial[XLEN-1:0] >= r_dvs);
            w_sub   = w_trial[XLEN-1:0] - r_dvs;
            w_quo_n = {w_quo_n[XLEN-2:0], w_ge};
            w_rem_n = w_ge ? w_sub : w_trial[XLEN-1:0];
        end
    end

    // ---------------------------------------------------------------
    // Sign fix-up and RISC-V special cases
    // ---------------------------------------------------------------
    logic            w_dsgn;
    logic            w_qneg;
    logic            w_rneg;
    logic            w_dz;
    logic [XLEN-1:0] w_q_fix;
    logic [XLEN-1:0] w_r_fix;
    logic [XLEN-1:0] w_div_res;

    assign w_dsgn    = ~r_op[0];
    assign w_qneg    = w_dsgn & (r_a[XLEN-1] ^ r_b[XLEN-1]);
    assign w_rneg    = w_dsgn & r_a[XLEN-1];
    assign w_dz      = (r_b == '0);
    assign w_q_fix   = w_dz ? '1 : (w_qneg ? -r_quo : r_quo);
    assign w_r_fix   = w_dz ? r_a : (w_rneg ? -r_rem : r_rem);
    assign w_div_res = r_op[1] ? w_r_fix : w_q_fix;

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_dvs       <= '0;
            r_quo       <= '0;
            r_rem       <= '0;
            r_result    <= '0;
            r_completed <= 1'b0;
        end else begin
            r_completed <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (enabled) begin
                        r_op  <= op[1:0];
                        r_a   <= rs1;
                        r_b   <= rs2;
                        r_dvs <= w_abs2;
                        r_quo <= w_abs1;
                        r_rem <= '0;
                        r_cnt <= op[2] ? DIV_INIT : MUL_INIT;
                    end
                end
                S_MUL: begin
                    if (r_cnt == '0) begin
                        r_result    <= w_mul_res;
                        r_completed <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DIV_CALC: begin
                    r_quo <= w_quo_n;
                    r_rem <= w_rem_n;
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DIV_FIX: begin
                    r_result    <= w_div_res;
                    r_completed <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a default 32-bit instance and a
// 64-bit radix-4 instance sharing clock and reset.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        en32;
    logic [2:0]  op32;
    logic [31:0] a32;
    logic [31:0] b32;
    logic        rdy32;
    logic        cmp32;
    logic [31:0] res32;
    logic        en64;
    logic [2:0]  op64;
    logic [63:0] a64;
    logic [63:0] b64;
    logic        rdy64;
    logic        cmp64;
    logic [63:0] res64;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_unit dut32 (
        .clk       (clk),
        .rst       (rst),
        .enabled   (en32),
        .op        (op32),
        .rs1       (a32),
        .rs2       (b32),
        .ready     (rdy32),
        .completed (cmp32),
        .result    (res32)
    );

    muldiv_unit #(
        .XLEN       (64),
        .MUL_STAGES (2),
        .DIV_RADIX  (4)
    ) dut64 (
        .clk       (clk),
        .rst       (rst),
        .enabled   (en64),
        .op        (op64),
        .rs1       (a64),
        .rs2       (b64),
        .ready     (rdy64),
        .completed (cmp64),
        .result    (res64)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Issues one op; returns at the completion cycle (or lat=-1 on timeout).
    task automatic run32(input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, output int lat,
                         output logic [31:0] res, output bit busy_ok);
        en32 = 1'b1;
        op32 = o;
        a32  = a;
        b32  = b;
        @(posedge clk);
        #1;
        en32    = 1'b0;
        lat     = -1;
        busy_ok = !rdy32 && !cmp32;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if (cmp32) begin
                lat = k;
                break;
            end
            if (rdy32) busy_ok = 1'b0;
        end
        res = res32;
    endtask

    task automatic run64(input logic [2:0] o, input logic [63:0] a,
                         input logic [63:0] b, output int lat,
                         output logic [63:0] res, output bit busy_ok);
        en64 = 1'b1;
        op64 = o;
        a64  = a;
        b64  = b;
        @(posedge clk);
        #1;
        en64    = 1'b0;
        lat     = -1;
        busy_ok = !rdy64 && !cmp64;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if (cmp64) begin
                lat = k;
                break;
            end
            if (rdy64) busy_ok = 1'b0;
        end
        res = res64;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        en32 = 1'b0;
        en64 = 1'b0;
        op32 = '0;
        op64 = '0;
        a32  = '0;
        b32  = '0;
        a64  = '0;
        b64  = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rdy32 !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready32: got %b expected 1", rdy32);
        end
        checks++;
        if (cmp32 !== 1'b0) begin
            errors++;
            $display("FAIL reset_completed32: got %b expected 0", cmp32);
        end
        checks++;
        if (res32 !== 32'h0) begin
            errors++;
            $display("FAIL reset_result32: got %h expected 0", res32);
        end
        checks++;
        if (rdy64 !== 1'b1 || cmp64 !== 1'b0 || res64 !== 64'h0) begin
            errors++;
            $display("FAIL reset_64: got rdy=%b cmp=%b res=%h expected 1 0 0",
                     rdy64, cmp64, res64);
        end
        rst = 1'b0;
    endtask

    task automatic test_mul();
        int          lat;
        logic [31:0] res;
        bit          busy_ok;
        run32(3'd0, 32'd7, 32'hFFFFFFFD, lat, res, busy_ok);
        checks++;
        if (res !== 32'hFFFFFFEB) begin
            errors++;
            $display("FAIL mul_result: got %h expected ffffffeb", res);
        end
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL mul_latency: got %0d expected 2", lat);
        end
        checks++;
        if (!busy_ok) begin
            errors++;
            $display("FAIL mul_busy_ready: got ready high expected low");
        end
        checks++;
        if (rdy32 !== 1'b1) begin
            errors++;
            $display("FAIL mul_ready_on_done: got %b expected 1", rdy32);
        end
        @(posedge clk);
        #1;
        checks++;
        if (cmp32 !== 1'b0) begin
            errors++;
            $display("FAIL mul_pulse_width: got %b expected 0", cmp32);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (res32 !== 32'hFFFFFFEB) begin
            errors++;
            $display("FAIL mul_result_hold: got %h expected ffffffeb", res32);
        end
    endtask

    task automatic test_mulh();
        logic [2:0]  ops [6] = '{3'd3, 3'd1, 3'd2, 3'd3, 3'd1, 3'd2};
        logic [31:0] as  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                 32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFD};
        logic [31:0] bs  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                 32'd7, 32'd7, 32'd7};
        logic [31:0] ex  [6] = '{32'hFFFFFFFE, 32'h0, 32'hFFFFFFFF,
                                 32'h6, 32'hFFFFFFFF, 32'hFFFFFFFF};
        int          lat;
        logic [31:0] res;
        bit          busy_ok;
        for (int i = 0; i < 6; i++) begin
            run32(ops[i], as[i], bs[i], lat, res, busy_ok);
            checks++;
            if (res !== ex[i] || lat !== 2) begin
                errors++;
                $display("FAIL mulh_vec%0d: got %h lat %0d expected %h lat 2",
                         i, res, lat, ex[i]);
            end
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops [6] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd7};
        logic [31:0] as  [6] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100,
                                 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF9};
        logic [31:0] bs  [6] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd2, 32'd2};
        logic [31:0] ex  [6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14,
                                 32'd2, 32'h7FFFFFFC, 32'd1};
        int          lat;
        logic [31:0] res;
        bit          busy_ok;
        for (int i = 0; i < 6; i++) begin
            run32(ops[i], as[i], bs[i], lat, res, busy_ok);
            checks++;
            if (res !== ex[i]) begin
                errors++;
                $display("FAIL div_vec%0d_result: got %h expected %h",
                         i, res, ex[i]);
            end
            checks++;
            if (lat !== 33 || !busy_ok) begin
                errors++;
                $display("FAIL div_vec%0d_timing: got lat %0d busy_ok %0d expected 33 1",
                         i, lat, busy_ok);
            end
        end
    endtask

    task automatic test_div_special();
        logic [2:0]  ops [6] = '{3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
        logic [31:0] as  [6] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000,
                                 32'hFFFFFFF9, 32'hFFFFFFF9};
        logic [31:0] bs  [6] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                 32'd0, 32'd0};
        logic [31:0] ex  [6] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0,
                                 32'hFFFFFFFF, 32'hFFFFFFF9};
        int          lat;
        logic [31:0] res;
        bit          busy_ok;
        for (int i = 0; i < 6; i++) begin
            run32(ops[i], as[i], bs[i], lat, res, busy_ok);
            checks++;
            if (res !== ex[i] || lat !== 33) begin
                errors++;
                $display("FAIL divspec_vec%0d: got %h lat %0d expected %h lat 33",
                         i, res, lat, ex[i]);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int lat;
        en32 = 1'b1;
        op32 = 3'd5;
        a32  = 32'd100;
        b32  = 32'd7;
        @(posedge clk);
        #1;
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            a32 = $urandom;
            b32 = $urandom;
            @(posedge clk);
            #1;
            if (cmp32) begin
                lat = k;
                break;
            end
        end
        checks++;
        if (res32 !== 32'd14 || lat !== 33) begin
            errors++;
            $display("FAIL busy_ignore: got %h lat %0d expected 0000000e lat 33",
                     res32, lat);
        end
        op32 = 3'd4;
        a32  = 32'hFFFFFFF9;
        b32  = 32'd2;
        @(posedge clk);
        #1;
        en32 = 1'b0;
        checks++;
        if (rdy32 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: got ready %b expected 0", rdy32);
        end
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if (cmp32) begin
                lat = k;
                break;
            end
        end
        checks++;
        if (res32 !== 32'hFFFFFFFD || lat !== 33) begin
            errors++;
            $display("FAIL b2b_div: got %h lat %0d expected fffffffd lat 33",
                     res32, lat);
        end
    endtask

    task automatic test_back_to_back();
        int          lat;
        logic [31:0] res;
        bit          busy_ok;
        run32(3'd7, 32'd100, 32'd7, lat, res, busy_ok);
        run32(3'd0, 32'd6, 32'd9, lat, res, busy_ok);
        checks++;
        if (res !== 32'd54 || lat !== 2) begin
            errors++;
            $display("FAIL b2b_div_then_mul: got %h lat %0d expected 00000036 lat 2",
                     res, lat);
        end
        run32(3'd5, 32'd1000, 32'd10, lat, res, busy_ok);
        checks++;
        if (res !== 32'd100 || lat !== 33) begin
            errors++;
            $display("FAIL b2b_mul_then_div: got %h lat %0d expected 00000064 lat 33",
                     res, lat);
        end
    endtask

    task automatic test_reset_abort();
        bit pulsed = 1'b0;
        bit idle_ok = 1'b1;
        en32 = 1'b1;
        op32 = 3'd4;
        a32  = 32'hFFFFFFF9;
        b32  = 32'd2;
        @(posedge clk);
        #1;
        en32 = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
            if (cmp32) pulsed = 1'b1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (rdy32 !== 1'b1 || res32 !== 32'h0) begin
            errors++;
            $display("FAIL abort_reset_state: got rdy %b res %h expected 1 0",
                     rdy32, res32);
        end
        repeat (40) begin
            @(posedge clk);
            #1;
            if (cmp32) pulsed = 1'b1;
            if (!rdy32) idle_ok = 1'b0;
        end
        checks++;
        if (pulsed) begin
            errors++;
            $display("FAIL abort_no_completed: got pulse expected none");
        end
        checks++;
        if (!idle_ok) begin
            errors++;
            $display("FAIL abort_stays_idle: got ready low expected high");
        end
    endtask

    task automatic test_div64();
        logic [2:0]  ops [9] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd7,
                                 3'd4, 3'd6, 3'd3};
        logic [63:0] as  [9] = '{64'hFFFFFFFFFFFFFFF9, 64'hFFFFFFFFFFFFFFF9,
                                 64'd100, 64'd100, 64'd5, 64'd5,
                                 64'h8000000000000000, 64'h8000000000000000,
                                 64'hFFFFFFFFFFFFFFFF};
        logic [63:0] bs  [9] = '{64'd2, 64'd2, 64'd7, 64'd7, 64'd0, 64'd0,
                                 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
                                 64'hFFFFFFFFFFFFFFFF};
        logic [63:0] ex  [9] = '{64'hFFFFFFFFFFFFFFFD, 64'hFFFFFFFFFFFFFFFF,
                                 64'd14, 64'd2, 64'hFFFFFFFFFFFFFFFF, 64'd5,
                                 64'h8000000000000000, 64'h0,
                                 64'hFFFFFFFFFFFFFFFE};
        int          el  [9] = '{17, 17, 17, 17, 17, 17, 17, 17, 2};
        int          lat;
        logic [63:0] res;
        bit          busy_ok;
        for (int i = 0; i < 9; i++) begin
            run64(ops[i], as[i], bs[i], lat, res, busy_ok);
            checks++;
            if (res !== ex[i] || lat !== el[i] || !busy_ok) begin
                errors++;
                $display("FAIL x64_vec%0d: got %h lat %0d busy_ok %0d expected %h lat %0d",
                         i, res, lat, busy_ok, ex[i], el[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_div_special();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        test_div64();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
